// File: rtl/modmem_scan_ctrl.sv
// ---------------------------------------------------------------------------
// modmem_scan_ctrl
//   Read-scan sequencer for the template ROM bank. It streams one template
//   word per cycle out of both ROM ports. Port A covers [0, len-1] and port B
//   covers [HALF, HALF+len-1], wrapping modulo 2^AW. The ROM has a fixed read
//   latency of one cycle, and a valid/ready handshake toward the matching
//   datapath marks when mod_bus carries word rd_idx.
//
// Ports
//   clk       in   1     system clock, all state on rising edge
//   rst_n     in   1     asynchronous active-low reset
//   start     in   1     scan request, sampled only while idle
//   abort     in   1     synchronous cancel back to idle, no done pulse
//   len       in   AW+1  words to scan, latched at start, clamped to DEPTH
//   busy      out  1     scan in progress (through the done cycle)
//   done      out  1     one-cycle completion pulse
//   addr0     out  AW    ROM port-A address
//   addr1     out  AW    ROM port-B address
//   rd_valid  out  1     mod_bus holds word rd_idx this cycle
//   rd_ready  in   1     consumer accepts the word when rd_valid & rd_ready
//   rd_idx    out  AW    word index of the data currently on mod_bus
//   rd_first  out  1     rd_valid on word 0
//   rd_last   out  1     rd_valid on the final word
// ---------------------------------------------------------------------------
module modmem_scan_ctrl #(
  parameter int AW    = 10,
  parameter int DEPTH = 512,
  parameter int HALF  = 512
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] addr0,
  output logic [AW-1:0] addr1,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [AW-1:0] rd_idx,
  output logic          rd_first,
  output logic          rd_last
);

  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] HALF_A  = AW'(HALF);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW:0]   r_len_q;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] r_rd_idx;
  logic          r_rd_valid;

  logic [AW:0]   w_len_clamp;
  logic [AW:0]   w_len_m1;
  logic          w_adv;
  logic          w_idx_last;
  logic          w_stall;
  logic [AW-1:0] w_sel;

  assign w_len_clamp = (len > DEPTH_L) ? DEPTH_L : len;
  assign w_len_m1    = r_len_q - (AW+1)'(1);

  // A new address is issued whenever the output slot is empty or being
  // emptied this cycle.
  assign w_adv      = (r_state == S_ISSUE) && (!r_rd_valid || rd_ready);
  assign w_idx_last = ({1'b0, r_idx} == w_len_m1);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state logic (abort overrides everything)
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state_nxt = (len != '0) ? S_ISSUE : S_DONE;
          end
        end
        S_ISSUE: begin
          if (w_adv && w_idx_last) begin
            w_state_nxt = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (rd_ready) begin
            w_state_nxt = S_DONE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Scan datapath: index counter, output slot tracking the 1-cycle ROM read
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len_q    <= '0;
      r_idx      <= '0;
      r_rd_idx   <= '0;
      r_rd_valid <= 1'b0;
    end else if (abort) begin
      r_idx      <= '0;
      r_rd_idx   <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len_q <= w_len_clamp;
            r_idx   <= '0;
          end
        end
        S_ISSUE: begin
          if (w_adv) begin
            r_rd_valid <= 1'b1;
            r_rd_idx   <= r_idx;
            // Hold on the final word so idx never runs past len_q-1.
            if (!w_idx_last) begin
              r_idx <= r_idx + AW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (rd_ready) begin
            r_rd_valid <= 1'b0;
            r_idx      <= '0;
            r_rd_idx   <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM outputs and address mux. While a word is stalled, the ROM keeps
  // re-reading that same word so mod_bus holds steady. The mux is driven
  // combinationally from rd_ready.
  // --------------------------------------------------------------------------
  always_comb begin
    w_stall = ((r_state == S_ISSUE) || (r_state == S_DRAIN)) && r_rd_valid && !rd_ready;
    w_sel   = w_stall ? r_rd_idx : r_idx;
    busy    = (r_state != S_IDLE);
    done    = (r_state == S_DONE);
  end

  assign addr0    = w_sel;
  assign addr1    = w_sel + HALF_A;
  assign rd_valid = r_rd_valid;
  assign rd_idx   = r_rd_idx;
  assign rd_first = r_rd_valid && (r_rd_idx == '0);
  assign rd_last  = r_rd_valid && ({1'b0, r_rd_idx} == w_len_m1);

endmodule

// File: tb/tb_modmem_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_modmem_scan_ctrl
//   Scoreboard bench for modmem_scan_ctrl. Two instances share all inputs:
//   one uses the default HALF=512 and the other uses HALF=1000, so the port-B
//   wrap is exercised. A behavioural 1-cycle ROM feeds the word checks.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_modmem_scan_ctrl;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          rd_ready = 1'b0;
  logic [AW:0]   len = '0;

  logic          busy_a, done_a, rd_valid_a, first_a, last_a;
  logic [AW-1:0] addr0_a, addr1_a, rd_idx_a;
  logic          busy_h, done_h, rd_valid_h, first_h, last_h;
  logic [AW-1:0] addr0_h, addr1_h, rd_idx_h;

  modmem_scan_ctrl #(.AW(AW), .DEPTH(512), .HALF(512)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .len(len),
    .busy(busy_a), .done(done_a), .addr0(addr0_a), .addr1(addr1_a),
    .rd_valid(rd_valid_a), .rd_ready(rd_ready), .rd_idx(rd_idx_a),
    .rd_first(first_a), .rd_last(last_a)
  );

  modmem_scan_ctrl #(.AW(AW), .DEPTH(512), .HALF(1000)) u_dut_h (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .len(len),
    .busy(busy_h), .done(done_h), .addr0(addr0_h), .addr1(addr1_h),
    .rd_valid(rd_valid_h), .rd_ready(rd_ready), .rd_idx(rd_idx_h),
    .rd_first(first_h), .rd_last(last_h)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input logic [AW-1:0] a);
    return {a, 6'h00} ^ 16'hA5C3 ^ {6'h00, a};
  endfunction

  // 1-cycle-latency ROM model for both ports of both instances
  logic [15:0] q0_a, q1_a, q0_h, q1_h;
  always @(posedge clk) begin
    q0_a <= rom_word(addr0_a);
    q1_a <= rom_word(addr1_a);
    q0_h <= rom_word(addr0_h);
    q1_h <= rom_word(addr1_h);
  end

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int lq_cur = 0;
  int sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output monitor: every valid cycle is checked against the scoreboard head;
  // an accepted handshake (not cancelled by abort) pops it.
  always @(negedge clk) begin
    int e;
    if (rst_n) begin
      if (done_a) done_cnt++;
      if (rd_valid_a) begin
        if (sb.size() == 0) begin
          chk("extra_valid", 1, 0);
        end else begin
          e = sb[0];
          chk("rd_idx", rd_idx_a, e);
          chk("rd_first", first_a, (e == 0));
          chk("rd_last", last_a, (e == lq_cur - 1));
          chk("word0", q0_a, rom_word(AW'(e)));
          chk("word1", q1_a, rom_word(AW'(e + 512)));
          chk("rd_idx_h", rd_idx_h, e);
          chk("rd_last_h", last_h, (e == lq_cur - 1));
          chk("word1_h", q1_h, rom_word(AW'(e + 1000)));
          if (rd_ready && !abort) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_done"}, done_a, 0);
    chk({tag, "_valid"}, rd_valid_a, 0);
    chk({tag, "_addr0"}, addr0_a, 0);
    chk({tag, "_addr1"}, addr1_a, 512);
    chk({tag, "_addr1_h"}, addr1_h, 1000);
  endtask

  // mode 0: ready held high; 1: 3-cycle stall on word 2;
  // 2: random ready; 3: extra start pulse while busy
  task automatic scan(input int l, input int mode, input int exp_cyc, input string tag);
    int lq, cyc, d0, stalls;
    bit dn;
    lq = (l > 512) ? 512 : l;
    lq_cur = lq;
    d0 = done_cnt;
    dn = 0;
    stalls = 0;
    for (int i = 0; i < lq; i++) sb.push_back(i);
    len = (AW+1)'(l);
    start = 1'b1;
    rd_ready = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!dn && cyc < 3000) begin
      case (mode)
        1: begin
          if (rd_valid_a && rd_idx_a == 2 && stalls < 3) begin
            rd_ready = 1'b0;
            stalls++;
          end else begin
            rd_ready = 1'b1;
          end
        end
        2: rd_ready = 1'($urandom_range(0, 1));
        3: begin
          rd_ready = 1'b1;
          start = (cyc == 5);
        end
        default: rd_ready = 1'b1;
      endcase
      @(negedge clk);
      chk({tag, "_busy_run"}, busy_a, 1);
      if (mode == 1 && !rd_ready) chk({tag, "_stall_addr0"}, addr0_a, 2);
      if (done_a) begin
        dn = 1;
        if (exp_cyc >= 0) chk({tag, "_latency"}, cyc, exp_cyc);
        chk({tag, "_done_h"}, done_h, 1);
      end
      tick();
      start = 1'b0;
      cyc++;
    end
    chk({tag, "_done_seen"}, dn, 1);
    chk({tag, "_words_left"}, sb.size(), 0);
    sb.delete();
    @(negedge clk);
    check_idle({tag, "_after"});
    chk({tag, "_done_count"}, done_cnt - d0, 1);
    tick();
  endtask

  initial begin
    int st, d0;
    bit ab;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    chk("reset_rd_idx", rd_idx_a, 0);
    chk("reset_first", first_a, 0);
    chk("reset_last", last_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    scan(4, 0, 6, "t1_len4");
    scan(8, 1, 13, "t2_stall");
    scan(0, 0, 1, "t3_len0");
    scan(40, 0, 42, "t4_wrap");

    // abort while stalled on word 5, with ready raised in the same cycle
    lq_cur = 8;
    for (int i = 0; i < 8; i++) sb.push_back(i);
    len = 11'd8;
    start = 1'b1;
    rd_ready = 1'b1;
    tick();
    start = 1'b0;
    st = 0;
    ab = 0;
    for (int c = 0; c < 50 && !ab; c++) begin
      if (rd_valid_a && rd_idx_a == 5) begin
        if (st < 2) begin
          rd_ready = 1'b0;
          st++;
        end else begin
          rd_ready = 1'b1;
          abort = 1'b1;
          ab = 1;
        end
      end else begin
        rd_ready = 1'b1;
      end
      tick();
      abort = 1'b0;
    end
    chk("t5_abort_reached", ab, 1);
    @(negedge clk);
    check_idle("t5_abort");
    chk("t5_words_left", sb.size(), 3);
    sb.delete();
    d0 = done_cnt;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t5_quiet_valid", rd_valid_a, 0);
    end
    chk("t5_no_done", done_cnt - d0, 0);
    tick();

    scan(1023, 3, 514, "t6_clamp");
    scan(13, 2, -1, "rnd_ready");

    // asynchronous reset in the middle of a scan
    lq_cur = 20;
    for (int i = 0; i < 20; i++) sb.push_back(i);
    len = 11'd20;
    start = 1'b1;
    rd_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    chk("async_rst_rd_idx", rd_idx_a, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    scan(3, 0, 5, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
